// File: rtl/simple_pkg.sv
// Shared execute-datapath encodings: ALU/shifter opcodes, branch condition codes
// and the flag-commit rule, reused by the ALU, shifter and commit stage.
package simple_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_CMP = 4'b0101,
    OP_MOV = 4'b0110,
    OP_NOT = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1010,
    OP_ROR = 4'b1011
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BE   = 3'b000,
    BR_BLT  = 3'b001,
    BR_BLE  = 3'b010,
    BR_BNE  = 3'b011,
    BR_B    = 3'b100,
    BR_RSV5 = 3'b101,
    BR_RSV6 = 3'b110,
    BR_RSV7 = 3'b111
  } br_cond_e;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic op_sets_flags(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP,
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_keeps_v(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_CMP: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Carry is never architecturally committed; overflow only survives arithmetic ops.
  function automatic logic [3:0] commit_flags(input logic [3:0] szcv, input logic [3:0] op);
    return {szcv[FLAG_S], szcv[FLAG_Z], 1'b0, op_keeps_v(op) & szcv[FLAG_V]};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation against committed {S,Z,C,V} flags.
module branch_cond_eval
  import simple_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic w_s;
  logic w_z;
  logic w_v;
  logic w_lt;
  logic w_unused_c;

  assign w_s        = flags[FLAG_S];
  assign w_z        = flags[FLAG_Z];
  assign w_v        = flags[FLAG_V];
  assign w_lt       = w_s ^ w_v;
  assign w_unused_c = flags[FLAG_C];

  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_BE:   taken = w_z;
      BR_BLT:  taken = w_lt;
      BR_BLE:  taken = w_z | w_lt;
      BR_BNE:  taken = ~w_z;
      BR_B:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_commit_stage.sv
// Execute/commit stage: single-entry writeback register, committed flags and
// a one-cycle branch redirect evaluated against the flags already committed.
module exec_commit_stage
  import simple_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_szcv,
  input  logic [3:0]        alu_op,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic              br_en,
  input  logic [2:0]        br_cond,
  input  logic [DATA_W-1:0] br_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic              out_wb_en,
  output logic [REG_W-1:0]  out_wb_dst,
  output logic [3:0]        flags,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_res;
  logic              r_out_wb_en;
  logic [REG_W-1:0]  r_out_wb_dst;
  logic [3:0]        r_flags;
  logic              r_br_taken;
  logic [DATA_W-1:0] r_br_addr;

  logic w_accept;
  logic w_load;
  logic w_branch;
  logic w_cond_taken;
  logic w_redirect;

  assign in_ready   = (~r_out_valid | out_ready) & ~flush;
  assign w_accept   = in_valid & in_ready;
  assign w_load     = w_accept & ~br_en;
  assign w_branch   = w_accept & br_en;
  assign w_redirect = w_branch & w_cond_taken;

  // Branches see the registered flags, so a flag-setter one cycle earlier is already visible.
  branch_cond_eval u_cond (
    .flags (r_flags),
    .cond  (br_cond),
    .taken (w_cond_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_res    <= '0;
      r_out_wb_en  <= 1'b0;
      r_out_wb_dst <= '0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_res    <= alu_res;
      r_out_wb_en  <= wb_en;
      r_out_wb_dst <= wb_dst;
    end else if (flush | out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (w_load && op_sets_flags(alu_op)) begin
      r_flags <= commit_flags(alu_szcv, alu_op);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_taken <= 1'b0;
      r_br_addr  <= '0;
    end else begin
      r_br_taken <= w_redirect;
      if (w_redirect) begin
        r_br_addr <= br_target;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_res    = r_out_res;
  assign out_wb_en  = r_out_wb_en;
  assign out_wb_dst = r_out_wb_dst;
  assign flags      = r_flags;
  assign br_taken   = r_br_taken;
  assign br_addr    = r_br_addr;

endmodule

// File: tb/tb_exec_commit_stage.sv
// Self-checking bench for exec_commit_stage: directed vector table, hand-written
// backpressure/reset sequences and randomized traffic against a reference model.
module tb_exec_commit_stage;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int NV     = 17;
  localparam int NRAND  = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_szcv, alu_op;
  logic              wb_en;
  logic [REG_W-1:0]  wb_dst;
  logic              br_en;
  logic [2:0]        br_cond;
  logic [DATA_W-1:0] br_target;
  logic              flush;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_res;
  logic              out_wb_en;
  logic [REG_W-1:0]  out_wb_dst;
  logic [3:0]        flags;
  logic              br_taken;
  logic [DATA_W-1:0] br_addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  exec_commit_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .alu_szcv(alu_szcv), .alu_op(alu_op),
    .wb_en(wb_en), .wb_dst(wb_dst), .br_en(br_en), .br_cond(br_cond),
    .br_target(br_target), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_wb_en(out_wb_en),
    .out_wb_dst(out_wb_dst), .flags(flags), .br_taken(br_taken), .br_addr(br_addr)
  );

  // ---------------- reference model ----------------
  logic              m_ov;
  logic [DATA_W-1:0] m_res;
  logic              m_wben;
  logic [REG_W-1:0]  m_dst;
  logic [3:0]        m_flags;
  logic              m_bt;
  logic [DATA_W-1:0] m_ba;

  task automatic model_reset();
    m_ov = 1'b0; m_res = '0; m_wben = 1'b0; m_dst = '0;
    m_flags = 4'b0000; m_bt = 1'b0; m_ba = '0;
  endtask

  function automatic logic model_ready();
    return (!m_ov || out_ready) && !flush;
  endfunction

  function automatic logic [3:0] model_flags(input logic [3:0] old, input logic [3:0] op,
                                             input logic [3:0] szcv);
    int o;
    o = int'(op);
    if (o == 0 || o == 1 || o == 5) return {szcv[3], szcv[2], 1'b0, szcv[0]};
    if ((o >= 2 && o <= 4) || (o >= 8 && o <= 11)) return {szcv[3], szcv[2], 2'b00};
    return old;
  endfunction

  function automatic logic model_cond(input logic [3:0] f, input logic [2:0] c);
    logic s, z, v;
    s = f[3]; z = f[2]; v = f[0];
    if (c == 3'd0) return z;
    if (c == 3'd1) return s != v;
    if (c == 3'd2) return z || (s != v);
    if (c == 3'd3) return !z;
    if (c == 3'd4) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic acc, take;
    acc  = in_valid && model_ready();
    take = acc && br_en && model_cond(m_flags, br_cond);
    m_bt = take;
    if (take) m_ba = br_target;
    if (acc && !br_en) begin
      m_ov = 1'b1; m_res = alu_res; m_wben = wb_en; m_dst = wb_dst;
      m_flags = model_flags(m_flags, alu_op, alu_szcv);
    end else if (flush || out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic br, input logic we, input logic [2:0] dst,
                       input logic [3:0] op, input logic [3:0] szcv, input logic [15:0] res,
                       input logic [2:0] cond, input logic [15:0] tgt, input logic fl,
                       input logic ordy);
    in_valid = v; br_en = br; wb_en = we; wb_dst = dst; alu_op = op; alu_szcv = szcv;
    alu_res = res; br_cond = cond; br_target = tgt; flush = fl; out_ready = ordy;
  endtask

  task automatic step();
    #1;
    chk("in_ready", 32'(in_ready), 32'(model_ready()));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ov"},   32'(out_valid),  32'd0);
    chk({nm, "_res"},  32'(out_res),    32'd0);
    chk({nm, "_wben"}, 32'(out_wb_en),  32'd0);
    chk({nm, "_dst"},  32'(out_wb_dst), 32'd0);
    chk({nm, "_flg"},  32'(flags),      32'd0);
    chk({nm, "_bt"},   32'(br_taken),   32'd0);
    chk({nm, "_ba"},   32'(br_addr),    32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v, br;
    logic [3:0]  op, szcv;
    logic [15:0] res;
    logic [2:0]  cond;
    logic [15:0] tgt;
    logic        fl;
    logic        e_ov;
    logic [15:0] e_res;
    logic [3:0]  e_flags;
    logic        e_bt;
    logic [15:0] e_ba;
  } vec_t;

  vec_t tbl[NV];

  function automatic vec_t mk(input logic v, input logic br, input logic [3:0] op,
                              input logic [3:0] szcv, input logic [15:0] res,
                              input logic [2:0] cond, input logic [15:0] tgt, input logic fl,
                              input logic e_ov, input logic [15:0] e_res,
                              input logic [3:0] e_flags, input logic e_bt,
                              input logic [15:0] e_ba);
    vec_t t;
    t.v = v; t.br = br; t.op = op; t.szcv = szcv; t.res = res; t.cond = cond; t.tgt = tgt;
    t.fl = fl; t.e_ov = e_ov; t.e_res = e_res; t.e_flags = e_flags; t.e_bt = e_bt;
    t.e_ba = e_ba;
    return t;
  endfunction

  initial begin
    //             v  br op       szcv     res      cond  tgt      fl   ov  res      flags    bt  ba
    tbl[0]  = mk(1, 0, 4'b0001, 4'b0100, 16'h0000, 3'd0, 16'h0000, 0,  1, 16'h0000, 4'b0100, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 4'b0101, 4'b1000, 16'h1234, 3'd0, 16'h0000, 0,  1, 16'h1234, 4'b1000, 0, 16'h0000);
    tbl[2]  = mk(1, 1, 4'b0000, 4'b0000, 16'hFFFF, 3'd1, 16'h0040, 0,  0, 16'h1234, 4'b1000, 1, 16'h0040);
    tbl[3]  = mk(1, 1, 4'b0000, 4'b0000, 16'hFFFF, 3'd0, 16'h0080, 0,  0, 16'h1234, 4'b1000, 0, 16'h0040);
    tbl[4]  = mk(1, 0, 4'b0110, 4'b0100, 16'h00AA, 3'd0, 16'h0000, 0,  1, 16'h00AA, 4'b1000, 0, 16'h0040);
    tbl[5]  = mk(1, 0, 4'b1000, 4'b0111, 16'h0100, 3'd0, 16'h0000, 0,  1, 16'h0100, 4'b0100, 0, 16'h0040);
    tbl[6]  = mk(1, 0, 4'b0000, 4'b1011, 16'h7FFF, 3'd0, 16'h0000, 0,  1, 16'h7FFF, 4'b1001, 0, 16'h0040);
    tbl[7]  = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 3'd2, 16'h0200, 0,  0, 16'h7FFF, 4'b1001, 0, 16'h0040);
    tbl[8]  = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 3'd4, 16'h0300, 0,  0, 16'h7FFF, 4'b1001, 1, 16'h0300);
    tbl[9]  = mk(0, 0, 4'b0000, 4'b1111, 16'hBEEF, 3'd4, 16'h0999, 0,  0, 16'h7FFF, 4'b1001, 0, 16'h0300);
    tbl[10] = mk(1, 0, 4'b0111, 4'b1111, 16'h5555, 3'd0, 16'h0000, 0,  1, 16'h5555, 4'b1001, 0, 16'h0300);
    tbl[11] = mk(1, 1, 4'b0000, 4'b0100, 16'hAAAA, 3'd3, 16'h0444, 0,  0, 16'h5555, 4'b1001, 1, 16'h0444);
    tbl[12] = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 3'd5, 16'h0555, 0,  0, 16'h5555, 4'b1001, 0, 16'h0444);
    tbl[13] = mk(1, 0, 4'b0010, 4'b0111, 16'h0001, 3'd0, 16'h0000, 0,  1, 16'h0001, 4'b0100, 0, 16'h0444);
    tbl[14] = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 3'd0, 16'h0666, 0,  0, 16'h0001, 4'b0100, 1, 16'h0666);
    tbl[15] = mk(1, 0, 4'b0100, 4'b1000, 16'h00F0, 3'd0, 16'h0000, 0,  1, 16'h00F0, 4'b1000, 0, 16'h0666);
    tbl[16] = mk(1, 0, 4'b0000, 4'b0100, 16'hDEAD, 3'd0, 16'h0000, 1,  0, 16'h00F0, 4'b1000, 0, 16'h0666);
  end

  // ---------------- main sequence ----------------
  initial begin
    drive(0, 0, 0, 3'd0, 4'd0, 4'd0, 16'h0, 3'd0, 16'h0, 0, 1);
    model_reset();
    #11;
    chk_all_zero("rst_init");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].br, 1'b1, 3'(i), tbl[i].op, tbl[i].szcv, tbl[i].res,
            tbl[i].cond, tbl[i].tgt, tbl[i].fl, 1'b1);
      step();
      chk($sformatf("vec%0d_ov", i),  32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_res", i), 32'(out_res),   32'(tbl[i].e_res));
      chk($sformatf("vec%0d_flg", i), 32'(flags),     32'(tbl[i].e_flags));
      chk($sformatf("vec%0d_bt", i),  32'(br_taken),  32'(tbl[i].e_bt));
      chk($sformatf("vec%0d_ba", i),  32'(br_addr),   32'(tbl[i].e_ba));
    end

    // backpressure: hold 3 cycles, then drain and refill on the same edge
    drive(1, 0, 1, 3'd5, 4'b0000, 4'b0000, 16'h1111, 3'd0, 16'h0, 0, 1);
    step();
    chk("bp_load_ov", 32'(out_valid), 32'd1);
    chk("bp_load_res", 32'(out_res), 32'h1111);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 3'd6, 4'b0000, 4'b1000, 16'h2222 + 16'(k), 3'd0, 16'h0, 0, 0);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_hold_ov", 32'(out_valid), 32'd1);
      chk("bp_hold_res", 32'(out_res), 32'h1111);
      chk("bp_hold_dst", 32'(out_wb_dst), 32'd5);
    end
    drive(1, 0, 1, 3'd7, 4'b0000, 4'b0000, 16'h2222, 3'd0, 16'h0, 0, 1);
    step();
    chk("bp_refill_ov", 32'(out_valid), 32'd1);
    chk("bp_refill_res", 32'(out_res), 32'h2222);
    chk("bp_refill_dst", 32'(out_wb_dst), 32'd7);
    drive(0, 0, 0, 3'd0, 4'b0000, 4'b0000, 16'h0, 3'd0, 16'h0, 0, 1);
    step();
    chk("bp_drain_ov", 32'(out_valid), 32'd0);

    // asynchronous reset while br_taken is high
    drive(1, 1, 0, 3'd0, 4'b0000, 4'b0000, 16'h0, 3'd4, 16'h0ABC, 0, 1);
    step();
    chk("pre_rst_bt", 32'(br_taken), 32'd1);
    chk("pre_rst_ba", 32'(br_addr), 32'h0ABC);
    drive(0, 0, 0, 3'd0, 4'b0000, 4'b0000, 16'h0, 3'd0, 16'h0, 0, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_bt");
    model_reset();
    #1 rst = 1'b0;

    // asynchronous reset while an entry is held
    drive(1, 0, 1, 3'd3, 4'b0000, 4'b1001, 16'h3333, 3'd0, 16'h0, 0, 0);
    step();
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    chk("pre_rst_flg", 32'(flags), 32'b1001);
    drive(0, 0, 0, 3'd0, 4'b0000, 4'b0000, 16'h0, 3'd0, 16'h0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_ov");
    model_reset();
    #1 rst = 1'b0;
    drive(1, 0, 1, 3'd2, 4'b0001, 4'b0100, 16'h0777, 3'd0, 16'h0, 0, 1);
    step();
    chk("post_rst_ov", 32'(out_valid), 32'd1);
    chk("post_rst_res", 32'(out_res), 32'h0777);
    chk("post_rst_flg", 32'(flags), 32'b0100);

    // randomized traffic against the model
    for (int n = 0; n < NRAND; n++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), 1'($urandom),
            3'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), 3'($urandom),
            16'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7));
      step();
      chk("rnd_ov",   32'(out_valid),  32'(m_ov));
      chk("rnd_res",  32'(out_res),    32'(m_res));
      chk("rnd_wben", 32'(out_wb_en),  32'(m_wben));
      chk("rnd_dst",  32'(out_wb_dst), 32'(m_dst));
      chk("rnd_flg",  32'(flags),      32'(m_flags));
      chk("rnd_bt",   32'(br_taken),   32'(m_bt));
      chk("rnd_ba",   32'(br_addr),    32'(m_ba));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
